// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract unit: one full adder (built from two half adders)
// processes the operands LSB-first with a registered carry feedback loop.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module FA_using_2HA (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1_s;
    logic c1_s;
    logic c2_s;

    half_adder ha0 (.x(a),    .y(b),  .s(s1_s), .c(c1_s));
    half_adder ha1 (.x(s1_s), .y(ci), .s(s),    .c(c2_s));

    assign co = c1_s | c2_s;
endmodule

module serial_add_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  sa_r;
    logic [WIDTH-1:0]  sb_r;
    logic [WIDTH-1:0]  sr_r;
    logic              c_r;
    logic [CW-1:0]     cnt_r;

    logic              fa_s;
    logic              fa_co;
    logic [WIDTH-1:0]  sr_next_s;

    FA_using_2HA u_fa (
        .a  (sa_r[0]),
        .b  (sb_r[0]),
        .ci (c_r),
        .s  (fa_s),
        .co (fa_co)
    );

    assign sr_next_s = {fa_s, sr_r[WIDTH-1:1]};

    // Control FSM, serial datapath and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sa_r    <= {WIDTH{1'b0}};
            sb_r    <= {WIDTH{1'b0}};
            sr_r    <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: the +1 rides in on the carry.
                        sa_r    <= a;
                        sb_r    <= sub ? ~b : b;
                        c_r     <= sub;
                        cnt_r   <= {CW{1'b0}};
                        sr_r    <= {WIDTH{1'b0}};
                        state_r <= RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    sr_r  <= sr_next_s;
                    c_r   <= fa_co;
                    sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        // On the MSB, c_r is the carry into the MSB; ovf = cin ^ cout.
                        sum     <= sr_next_s;
                        cout    <= fa_co;
                        ovf     <= c_r ^ fa_co;
                        zero    <= (sr_next_s == {WIDTH{1'b0}});
                        state_r <= DONE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit (WIDTH=8) with a result scoreboard.

module tb_serial_add_unit;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int           tests;
    int           fails;
    res_t         sb_q[$];
    logic [W-1:0] last_sum;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain wide arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        res_t         r;
        logic [W-1:0] yy;
        logic [W:0]   full;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        r.zero = (full[W-1:0] == {W{1'b0}});
        return r;
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        chk("ready_at_launch", {63'd0, ready}, 64'd1);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        sb_q.push_back(model(x, y, s));
    endtask

    // Clocks the launch edge, then waits (bounded) for done and scores it.
    task automatic wait_done(input int inject_at);
        int   k;
        res_t e;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < W + 4) begin
            chk("busy_in_run", {63'd0, busy}, 64'd1);
            chk("sum_hold", {56'd0, sum}, {56'd0, last_sum});
            if (k == inject_at) begin
                start = 1'b1;
                a     = 8'h3C;
                b     = 8'h11;
                sub   = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("latency", 64'(k), 64'(W));
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'(sb_q.size()));
        end else begin
            e = sb_q.pop_front();
            chk("sum",  {56'd0, sum},  {56'd0, e.sum});
            chk("cout", {63'd0, cout}, {63'd0, e.cout});
            chk("ovf",  {63'd0, ovf},  {63'd0, e.ovf});
            chk("zero", {63'd0, zero}, {63'd0, e.zero});
            last_sum = e.sum;
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        last_sum = 8'h00;
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_busy",  {63'd0, busy},  64'd0);
        chk("rst_done",  {63'd0, done},  64'd0);
        chk("rst_sum",   {56'd0, sum},   64'd0);
        chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);

        // Signed overflow into the MSB.
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(-1);
        chk("ovf_7f_01", {63'd0, ovf}, 64'd1);

        // Carry out with zero result, then a borrowing subtract.
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(-1);
        chk("zero_ff_01", {63'd0, zero}, 64'd1);
        tick();
        chk("done_pulse_one", {63'd0, done}, 64'd0);
        launch(8'h05, 8'h07, 1'b1);
        wait_done(-1);
        chk("sum_05_07", {56'd0, sum}, 64'hFE);

        // Subtract overflow; sum must hold 0xFE while running.
        tick();
        launch(8'h80, 8'h01, 1'b1);
        wait_done(-1);
        chk("sum_80_01", {56'd0, sum}, 64'h7F);

        // Start during RUN is ignored: one done, original result.
        tick();
        launch(8'h21, 8'h0F, 1'b0);
        wait_done(3);
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("no_extra_done", {63'd0, done}, 64'd0);
        end
        chk("idle_ready", {63'd0, ready}, 64'd1);

        // Reset mid-RUN discards the operation.
        launch(8'hAA, 8'h55, 1'b0);
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum",   {56'd0, sum},   64'd0);
        chk("mid_rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
        chk("mid_rst_busy",  {63'd0, busy},  64'd0);
        chk("mid_rst_ready", {63'd0, ready}, 64'd1);
        sb_q.delete();
        last_sum = 8'h00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("post_rst_no_done", {63'd0, done}, 64'd0);
        end
        launch(8'h12, 8'h34, 1'b0);
        wait_done(-1);
        chk("sum_12_34", {56'd0, sum}, 64'h46);

        // Back-to-back: launch in the DONE cycle; next done 9 cycles later.
        launch(8'h01, 8'h01, 1'b0);
        wait_done(-1);
        chk("sum_01_01", {56'd0, sum}, 64'h02);
        tick();
        chk("b2b_done_drop", {63'd0, done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
